reg_bank_write_arbiter: RTL and testbench
=========================================

Name: reg_bank_write_arbiter

Overview:
- Four requesters share the single write port of an internal bank of four WIDTH-bit D flip-flop registers.
- The block performs round-robin arbitration at every rising clock edge and writes the winner's data into the addressed register.
- An optional lock lets a requester take consecutive writes, capped at MAX_BURST.
- It sits between datapath units and the shared register bank, which has one combinational read port.

Parameters:
- WIDTH, 32, data width of each bank register.
- MAX_BURST, 4, maximum consecutive grants to a locked owner while another requester waits (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  asynchronous, active-low reset.
- req  input  4  req[i] high: requester i has a write pending.
- lock  input  4  lock[i] high with req[i]: requester i asks to keep ownership.
- wr_addr  input  8  requester i target register in bits [2i+1:2i].
- wr_data  input  4*WIDTH  requester i data in bits [WIDTH*(i+1)-1:WIDTH*i].
- gnt  output  4  registered one-hot; gnt[i] high means requester i's write completed at the previous edge.
- owner  output  2  index of the last granted requester.
- busy  output  1  high while in GRANT or BURST state.
- rd_addr  input  2  read select.
- rd_data  output  WIDTH  combinational bank[rd_addr].

Behaviour:
- Reset (res=0), asynchronous, regardless of clk:
  - gnt=0, owner=0, busy=0, state=IDLE, prio pointer=0, burst count=0.
  - All four bank registers cleared to 0, so rd_data=0.
- Reset asserted mid-burst aborts immediately; no write occurs at an edge while res=0.
- Arbitration at each rising edge with res=1:
  - If req==0: no write, gnt<=0, state<=IDLE. owner and prio are unchanged; burst count is cleared.
  - Otherwise the winner w is chosen by the rules below. Then:
    - bank[wr_addr[w]] <= wr_data[w].
    - gnt <= one-hot(w), owner <= w.
    - prio <= (w+1) mod 4.
- Winner selection:
  - In BURST state: w = owner if req[owner] is high and lock[owner] is high and either burst count < MAX_BURST or no other req bit is set.
  - In all other cases: w = the first set req bit scanning from prio upward, wrapping 3 to 0.
- Latency and handshake:
  - A write commits at the edge where the requester wins; gnt is visible for the whole following cycle.
  - A requester must hold req, wr_addr and wr_data stable until it sees gnt[i].
  - In the cycle where gnt[i] is high, the requester drops req[i] or presents the next word before the next edge.
  - If req[i] stays high after a grant, it is treated as a new request.
  - Exactly one write per edge maximum; gnt is never more than one-hot.
- States:
  - IDLE: no grant last cycle.
  - GRANT: single grant last cycle.
  - BURST: owner holds lock.
  - Transitions:
    - IDLE/GRANT -> BURST when the winner's lock is high, with count<=1.
    - IDLE/GRANT -> GRANT when the winner's lock is low.
    - BURST -> BURST while the owner continues, count<=count+1. When count==MAX_BURST and no other requester is pending, the owner continues and count<=1.
    - BURST -> GRANT or BURST (new owner, count<=1) when the owner is forced out by the cap, or drops lock or req.
    - Any state -> IDLE when req==0.
- busy = (state != IDLE).
- Read port:
  - rd_data reflects bank contents only. A write at edge n is visible on rd_data after edge n; there is no bypass before the edge.
- Simultaneous events:
  - Several requesters targeting the same address on successive edges: the last writer wins.
  - A lock bit without the matching req bit is ignored.

Test Plan:
1. Reset: hold res=0 for 10 ns with req=4'hF -> gnt=0, busy=0, rd_data=0 for rd_addr 0..3. Release res -> first grant goes to req0.
2. Single write: req=4'b0100, wr_addr[5:4]=2'd3, data2=32'h0000_0014 -> after one edge gnt=4'b0100, owner=2, bank[3]=32'h14; with req dropped, next cycle gnt=0 and busy=0.
3. Round robin: req=4'hF held continuously from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, each writing its own data to its own address.
4. Burst cap: MAX_BURST=4, req=4'b0011, lock[0]=1, start prio=0 -> gnt=0001 for four cycles, then 0010, then 0001 again.
5. Locked with no contender: req=4'b0001, lock[0]=1 for 10 cycles -> gnt=0001 every cycle; data incremented by 1 each cycle lands in bank[wr_addr0] with final value 10.
6. Mid-burst reset: res pulled low for 10 ns during cycle 3 of a burst -> gnt=0 and bank cleared immediately; after release, arbitration restarts from prio=0 in IDLE.

Source files
------------

// File: rtl/reg_bank_write_arbiter.sv
// rtl/reg_bank_write_arbiter.sv - round-robin write arbiter with lock/burst cap in front of a 4-entry register bank
module reg_bank_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               res,
    input  logic [3:0]         req,
    input  logic [3:0]         lock,
    input  logic [7:0]         wr_addr,
    input  logic [4*WIDTH-1:0] wr_data,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    input  logic [1:0]         rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t           state;
    logic [1:0]       prio;
    logic [3:0]       burst_cnt;
    logic [WIDTH-1:0] bank [4];

    logic             others_pending;
    logic             keep_owner;
    logic [1:0]       rr_win;
    logic [1:0]       win;
    logic [1:0]       win_addr;
    logic [WIDTH-1:0] win_data;

    // A locked owner keeps the port unless it has used up its cap while someone else waits
    always_comb begin
        others_pending = (req & ~(4'b0001 << owner)) != 4'b0000;
        keep_owner     = (state == BURST) && req[owner] && lock[owner] &&
                         ((burst_cnt < MAX_B) || !others_pending);
    end

    // Round-robin scan from prio upward; descending loop so the nearest set bit wins
    always_comb begin
        rr_win = prio;
        for (int k = 3; k >= 0; k--) begin
            if (req[prio + 2'(k)]) begin
                rr_win = prio + 2'(k);
            end
        end
    end

    // Select the winner and route its address and data to the bank write port
    always_comb begin
        win      = keep_owner ? owner : rr_win;
        win_addr = 2'd0;
        win_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                win_addr = wr_addr[2*i +: 2];
                win_data = wr_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // Arbitration state, registered grant outputs and the bank write
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            owner     <= 2'd0;
            prio      <= 2'd0;
            burst_cnt <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
        end else if (req == 4'b0000) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            burst_cnt <= 4'd0;
        end else begin
            bank[win_addr] <= win_data;
            gnt            <= 4'b0001 << win;
            owner          <= win;
            prio           <= win + 2'd1;
            if (keep_owner) begin
                state     <= BURST;
                burst_cnt <= (burst_cnt >= MAX_B) ? 4'd1 : burst_cnt + 4'd1;
            end else if (lock[win]) begin
                state     <= BURST;
                burst_cnt <= 4'd1;
            end else begin
                state     <= GRANT;
                burst_cnt <= 4'd0;
            end
        end
    end

    // Registered busy flag follows the state register
    always_comb begin
        busy = (state != IDLE);
    end

    // Combinational read port straight from the bank, no write bypass
    always_comb begin
        rd_data = bank[rd_addr];
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb/tb_reg_bank_write_arbiter.sv - directed self-checking bench for reg_bank_write_arbiter
module tb_reg_bank_write_arbiter;

    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic               clk;
    logic               res;
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [7:0]         wr_addr;
    logic [4*WIDTH-1:0] wr_data;
    logic [3:0]         gnt;
    logic [1:0]         owner;
    logic               busy;
    logic [1:0]         rd_addr;
    logic [WIDTH-1:0]   rd_data;

    int checks   = 0;
    int failures = 0;

    reg_bank_write_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .lock    (lock),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] d);
        wr_data[WIDTH*i +: WIDTH] = d;
    endtask

    task automatic pulse_reset();
        res = 1'b0;
        #10;
        res = 1'b1;
    endtask

    task automatic test_reset();
        res     = 1'b0;
        req     = 4'hF;
        lock    = 4'h0;
        rd_addr = 2'd0;
        wr_addr = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) set_data(i, 32'd100 + 32'(i));
        #6;
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt actual=%b expected=%b", gnt, 4'b0000);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy actual=%b expected=%b", busy, 1'b0);
        end
        checks++;
        if (owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_owner actual=%0d expected=%0d", owner, 0);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            checks++;
            if (rd_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_rd_data addr=%0d actual=%h expected=%h", a, rd_data, 32'd0);
            end
        end
        res = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant actual=%b expected=%b", gnt, 4'b0001);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_gnt = 4'b0001 << (k % 4);
            checks++;
            if (gnt !== exp_gnt) begin
                failures++;
                $display("FAIL rr_gnt step=%0d actual=%b expected=%b", k, gnt, exp_gnt);
            end
            checks++;
            if (owner !== 2'(k % 4)) begin
                failures++;
                $display("FAIL rr_owner step=%0d actual=%0d expected=%0d", k, owner, k % 4);
            end
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            checks++;
            if (rd_data !== 32'd100 + 32'(a)) begin
                failures++;
                $display("FAIL rr_bank addr=%0d actual=%0d expected=%0d", a, rd_data, 100 + a);
            end
        end
    endtask

    task automatic test_single_write();
        req = 4'b0100;
        wr_addr[5:4] = 2'd3;
        set_data(2, 32'h0000_0014);
        rd_addr = 2'd3;
        #1;
        checks++;
        if (rd_data !== 32'd103) begin
            failures++;
            $display("FAIL single_no_bypass actual=%h expected=%h", rd_data, 32'd103);
        end
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL single_gnt actual=%b expected=%b", gnt, 4'b0100);
        end
        checks++;
        if (owner !== 2'd2) begin
            failures++;
            $display("FAIL single_owner actual=%0d expected=%0d", owner, 2);
        end
        checks++;
        if (rd_data !== 32'h0000_0014) begin
            failures++;
            $display("FAIL single_bank actual=%h expected=%h", rd_data, 32'h14);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle actual=gnt %b busy %b expected=gnt 0000 busy 0", gnt, busy);
        end
        checks++;
        if (owner !== 2'd2) begin
            failures++;
            $display("FAIL single_owner_hold actual=%0d expected=%0d", owner, 2);
        end
    endtask

    task automatic test_burst_cap();
        logic [3:0] exp_seq [6];
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        req  = 4'b0000;
        lock = 4'b0000;
        pulse_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (gnt !== exp_seq[k] || busy !== 1'b1) begin
                failures++;
                $display("FAIL burst_cap_gnt step=%0d actual=gnt %b busy %b expected=gnt %b busy 1",
                         k, gnt, busy, exp_seq[k]);
            end
        end
    endtask

    task automatic test_lock_alone();
        req  = 4'b0000;
        step();
        req  = 4'b0001;
        lock = 4'b0001;
        wr_addr[1:0] = 2'd1;
        rd_addr = 2'd1;
        for (int k = 1; k <= 10; k++) begin
            set_data(0, 32'(k));
            step();
            checks++;
            if (gnt !== 4'b0001 || rd_data !== 32'(k)) begin
                failures++;
                $display("FAIL lock_alone step=%0d actual=gnt %b data %0d expected=gnt 0001 data %0d",
                         k, gnt, rd_data, k);
            end
        end
        checks++;
        if (rd_data !== 32'd10) begin
            failures++;
            $display("FAIL lock_alone_final actual=%0d expected=%0d", rd_data, 10);
        end
    endtask

    task automatic test_mid_burst_reset();
        req  = 4'b0000;
        step();
        req  = 4'b0001;
        lock = 4'b0001;
        wr_addr[1:0] = 2'd2;
        set_data(0, 32'h0000_00AA);
        rd_addr = 2'd2;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (rd_data !== 32'h0000_00AA) begin
            failures++;
            $display("FAIL mid_reset_prewrite actual=%h expected=%h", rd_data, 32'hAA);
        end
        res = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || rd_data !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_async actual=gnt %b busy %b data %h expected=gnt 0000 busy 0 data 0",
                     gnt, busy, rd_data);
        end
        #10;
        checks++;
        if (gnt !== 4'b0000 || rd_data !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_hold actual=gnt %b data %h expected=gnt 0000 data 0", gnt, rd_data);
        end
        res  = 1'b1;
        req  = 4'b1001;
        lock = 4'b0000;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle actual=%b expected=%b", busy, 1'b0);
        end
        step();
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_restart actual=gnt %b owner %0d busy %b expected=gnt 0001 owner 0 busy 1",
                     gnt, owner, busy);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_burst_cap();
        test_lock_alone();
        test_mid_burst_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
